// File: rtl/tx_pkg.sv
// Shared constants for the QPSK transmit source: symbol amplitude, PRBS9 seeds and taps,
// accumulator sizing and the root-raised-cosine taps.
package tx_pkg;

    localparam int COEF_WIDTH = 16;
    localparam int COEF_FRAC  = 15;
    localparam int ACC_GUARD  = 5;
    localparam int ACC_WIDTH  = 2 * COEF_WIDTH + ACC_GUARD;
    localparam int RRC_LEN    = 17;

    localparam logic signed [15:0] AMP = 16'sd16384;

    typedef logic [8:0] prbs9_t;

    localparam prbs9_t SEED_I     = 9'h1FF;
    localparam prbs9_t SEED_Q     = 9'h1AA;
    localparam int     PRBS_TAP_A = 8;
    localparam int     PRBS_TAP_B = 4;

    // RRC, rolloff 0.5, 4 samples/symbol, span 4 symbols; peak at the centre tap
    localparam logic signed [COEF_WIDTH-1:0] RRC_COEF [0:RRC_LEN-1] = '{
        16'sd612,    16'sd223,    -16'sd1081,  -16'sd2261,
        -16'sd1529,  16'sd2261,   16'sd8341,   16'sd14047,
        16'sd16384,
        16'sd14047,  16'sd8341,   16'sd2261,   -16'sd1529,
        -16'sd2261,  -16'sd1081,  16'sd223,    16'sd612
    };

    function automatic prbs9_t prbs9_next(input prbs9_t s);
        return {s[7:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
    endfunction

endpackage

// File: rtl/tx_rrc_fir.sv
// Direct-form RRC FIR: output register holds the sum over the current input and the
// delay line, rounded half-up to the sample width and saturated.
module tx_rrc_fir
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NTAPS      = RRC_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic signed [DATA_WIDTH-1:0] y_out
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = ACC_WIDTH - 2 * COEF_WIDTH + PROD_W;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX    = (ACC_W'(1) <<< (DATA_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;

    logic signed [DATA_WIDTH-1:0] dly_q [NTAPS-1];
    logic signed [DATA_WIDTH-1:0] tap   [NTAPS];
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_rnd;
    logic signed [ACC_W-1:0]      acc_sh;
    logic signed [DATA_WIDTH-1:0] y_d;
    logic signed [DATA_WIDTH-1:0] y_q;

    // tap 0 is the sample arriving this edge, so it contributes with no latency
    always_comb begin
        tap[0] = x_in;
        for (int k = 1; k < NTAPS; k++) begin
            tap[k] = dly_q[k-1];
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + ACC_W'(PROD_W'(tap[k]) * PROD_W'(RRC_COEF[k]));
        end
        acc_rnd = acc + RND_HALF;
        acc_sh  = acc_rnd >>> COEF_FRAC;
        if (acc_sh > Y_MAX) begin
            y_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (acc_sh < Y_MIN) begin
            y_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            y_d = acc_sh[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS - 1; k++) begin
                dly_q[k] <= '0;
            end
            y_q <= '0;
        end else if (en) begin
            dly_q[0] <= x_in;
            for (int k = 1; k < NTAPS - 1; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
            y_q <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: rtl/tx_top_qpsk.sv
// QPSK baseband source: per-branch PRBS9, bit-to-amplitude mapping, zero-stuffing by the
// oversampling phase and RRC shaping, one I/Q sample per enabled clock.
module tx_top_qpsk
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OS         = 4,
    parameter int NTAPS      = RRC_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic signed [DATA_WIDTH-1:0] tx_i,
    output logic signed [DATA_WIDTH-1:0] tx_q
);

    localparam int PH_W = (OS > 1) ? $clog2(OS) : 1;
    localparam logic signed [DATA_WIDTH-1:0] AMP_S = DATA_WIDTH'(AMP);

    logic [PH_W-1:0]              phase_q;
    logic [PH_W-1:0]              phase_d;
    prbs9_t                       prbs_i_q;
    prbs9_t                       prbs_i_d;
    prbs9_t                       prbs_q_q;
    prbs9_t                       prbs_q_d;
    logic                         sym_start;
    logic signed [DATA_WIDTH-1:0] x_i;
    logic signed [DATA_WIDTH-1:0] x_q;

    function automatic logic signed [DATA_WIDTH-1:0] map_bit(input logic b);
        return b ? -AMP_S : AMP_S;
    endfunction

    always_comb begin
        sym_start = (phase_q == '0);
        phase_d   = phase_q;
        prbs_i_d  = prbs_i_q;
        prbs_q_d  = prbs_q_q;
        x_i       = '0;
        x_q       = '0;
        if (en) begin
            phase_d = (phase_q == PH_W'(OS - 1)) ? '0 : phase_q + PH_W'(1);
            if (sym_start) begin
                prbs_i_d = prbs9_next(prbs_i_q);
                prbs_q_d = prbs9_next(prbs_q_q);
            end
        end
        // the emitted bit is the pre-advance MSB, only on the symbol phase
        if (sym_start) begin
            x_i = map_bit(prbs_i_q[PRBS_TAP_A]);
            x_q = map_bit(prbs_q_q[PRBS_TAP_A]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            prbs_i_q <= SEED_I;
            prbs_q_q <= SEED_Q;
        end else begin
            phase_q  <= phase_d;
            prbs_i_q <= prbs_i_d;
            prbs_q_q <= prbs_q_d;
        end
    end

    tx_rrc_fir #(
        .DATA_WIDTH (DATA_WIDTH),
        .NTAPS      (NTAPS)
    ) u_fir_i (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x_in  (x_i),
        .y_out (tx_i)
    );

    tx_rrc_fir #(
        .DATA_WIDTH (DATA_WIDTH),
        .NTAPS      (NTAPS)
    ) u_fir_q (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .x_in  (x_q),
        .y_out (tx_q)
    );

endmodule

// File: tb/tb_tx_top_qpsk.sv
// Scoreboard bench for tx_top_qpsk: stimulus pushes expected I/Q per edge, a monitor pops
// and compares 1 time unit after each rising edge; a standalone FIR exercises saturation.
module tb_tx_top_qpsk;

    localparam int NT   = 17;
    localparam int AMPV = 16384;
    localparam int H [NT] = '{612, 223, -1081, -2261, -1529, 2261, 8341, 14047, 16384,
                              14047, 8341, 2261, -1529, -2261, -1081, 223, 612};
    // first five samples after reset: symbols 0 and 1 are both -AMP on I and on Q
    localparam int HAND [5] = '{-306, -111, 541, 1131, 459};

    logic               clk     = 1'b0;
    logic               rst     = 1'b0;
    logic               en      = 1'b0;
    logic signed [15:0] tx_i;
    logic signed [15:0] tx_q;
    logic               sat_rst = 1'b0;
    logic               sat_en  = 1'b0;
    logic signed [15:0] sat_x   = '0;
    logic signed [15:0] sat_y;

    typedef struct {
        int ei;
        int eq;
        int idx;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         idx;
    int         last_i;
    int         last_q;
    logic [8:0] m_lfsr_i;
    logic [8:0] m_lfsr_q;
    int         m_phase;
    int         line_i[$];
    int         line_q[$];
    int         line_s[$];

    always #5 clk = ~clk;

    tx_top_qpsk dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tx_i (tx_i),
        .tx_q (tx_q)
    );

    tx_rrc_fir #(.DATA_WIDTH(16), .NTAPS(17)) sat_fir (
        .clk   (clk),
        .rst   (sat_rst),
        .en    (sat_en),
        .x_in  (sat_x),
        .y_out (sat_y)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int fir_ref(input int d[$]);
        longint acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(H[k]) * longint'(d[k]);
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic model_reset();
        m_lfsr_i = 9'h1FF;
        m_lfsr_q = 9'h1AA;
        m_phase  = 0;
        idx      = 0;
        last_i   = 0;
        last_q   = 0;
        line_i.delete();
        line_q.delete();
        for (int k = 0; k < NT; k++) begin
            line_i.push_back(0);
            line_q.push_back(0);
        end
    endtask

    task automatic model_step(output int yi, output int yq);
        int xi = 0;
        int xq = 0;
        if (m_phase == 0) begin
            xi = m_lfsr_i[8] ? -AMPV : AMPV;
            xq = m_lfsr_q[8] ? -AMPV : AMPV;
            m_lfsr_i = {m_lfsr_i[7:0], m_lfsr_i[8] ^ m_lfsr_i[4]};
            m_lfsr_q = {m_lfsr_q[7:0], m_lfsr_q[8] ^ m_lfsr_q[4]};
        end
        m_phase = (m_phase + 1) % 4;
        line_i.push_front(xi);
        void'(line_i.pop_back());
        line_q.push_front(xq);
        void'(line_q.pop_back());
        yi = fir_ref(line_i);
        yq = fir_ref(line_q);
    endtask

    // called at a falling edge: sets en for the next rising edge and queues its expectation
    task automatic issue(input logic en_v);
        int   yi;
        int   yq;
        exp_t e;
        en = en_v;
        if (en_v) begin
            model_step(yi, yq);
            if (idx < 5) begin
                yi = HAND[idx];
                yq = HAND[idx];
            end
            last_i = yi;
            last_q = yq;
            e.idx  = idx;
            idx++;
        end else begin
            e.idx = idx - 1;
        end
        e.ei = last_i;
        e.eq = last_q;
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: output at t=%0t, required a queued expectation", $time);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("tx_i[%0d]", mon_e.idx), 32'(tx_i), mon_e.ei);
                check($sformatf("tx_q[%0d]", mon_e.idx), 32'(tx_q), mon_e.eq);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        sat_rst = 1'b1;
        #1;
        check("rst_tx_i", 32'(tx_i), 0);
        check("rst_tx_q", 32'(tx_q), 0);
        check("rst_seed_i", 32'(dut.prbs_i_q), 32'h1FF);
        check("rst_seed_q", 32'(dut.prbs_q_q), 32'h1AA);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        while (idx < 38) begin
            issue(1'b1);
            if (idx == 1) check("prbs_i_step1", 32'(dut.prbs_i_q), 32'h1FE);
        end
        repeat (5) issue(1'b0);

        while (idx < 2050) begin
            issue(1'b1);
            if (idx % 4 == 0) begin
                check($sformatf("prbs_i_state@%0d", idx), 32'(dut.prbs_i_q), 32'(m_lfsr_i));
                check($sformatf("prbs_q_state@%0d", idx), 32'(dut.prbs_q_q), 32'(m_lfsr_q));
            end
            if (idx == 2044) check("prbs_i_period", 32'(dut.prbs_i_q), 32'h1FF);
        end

        // asynchronous reset mid-symbol, en still high
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_i", 32'(tx_i), 0);
        check("midrst_tx_q", 32'(tx_q), 0);
        check("midrst_seed_i", 32'(dut.prbs_i_q), 32'h1FF);
        check("midrst_seed_q", 32'(dut.prbs_q_q), 32'h1AA);
        check("midrst_phase", 32'(dut.phase_q), 0);
        @(posedge clk);
        #1;
        check("rst_hold_tx_i", 32'(tx_i), 0);
        check("rst_hold_tx_q", 32'(tx_q), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        while (idx < 60) issue(1'b1);
        issue(1'b0);
        rst = 1'b1;

        line_s.delete();
        for (int k = 0; k < NT; k++) line_s.push_back(0);
        sat_rst = 1'b0;
        sat_en  = 1'b1;
        for (int n = 0; n < 24; n++) begin
            sat_x = 16'sd32767;
            line_s.push_front(32767);
            void'(line_s.pop_back());
            @(posedge clk);
            #1;
            check($sformatf("sat_pos[%0d]", n), 32'(sat_y), fir_ref(line_s));
            @(negedge clk);
        end
        check("sat_pos_clamp", 32'(sat_y), 32767);
        for (int n = 0; n < 24; n++) begin
            sat_x = -16'sd32768;
            line_s.push_front(-32768);
            void'(line_s.pop_back());
            @(posedge clk);
            #1;
            check($sformatf("sat_neg[%0d]", n), 32'(sat_y), fir_ref(line_s));
            @(negedge clk);
        end
        check("sat_neg_clamp", 32'(sat_y), -32768);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached after %0d comparisons, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
